apb_demux_ctrl: RTL and testbench

Registered APB 1-to-N demultiplexer/bridge. It accepts one APB transfer from a single requester, decodes the target completer from the address, and replays the transfer on the selected slave port. The selected slave's response is returned to the requester. This block replaces the purely combinational slave-response mux with a sequenced bridge that has decode-error handling and an optional access timeout. It sits between the system APB requester and up to SLAVE_COUNT peripheral completers.

---
 rtl/apb_demux_ctrl_if.sv | 44 ++++
 rtl/apb_demux_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_apb_demux_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_demux_ctrl_if.sv
// APB demultiplexer bus bundle: requester-side signals (m_*) and the shared
// completer-side signals (sl_*). The "slave" modport is the bridge view, and the
// "master" modport is the environment view (requester plus completers).
interface apb_demux_ctrl_if #(
    parameter int SLAVE_COUNT = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
);
    // Requester side
    logic                                   m_psel_i;
    logic                                   m_penable_i;
    logic                                   m_pwrite_i;
    logic [ADDR_WIDTH-1:0]                  m_paddr_i;
    logic [DATA_WIDTH-1:0]                  m_pwdata_i;
    logic [DATA_WIDTH/8-1:0]                m_pstrb_i;
    logic                                   m_pready_o;
    logic                                   m_pslverr_o;
    logic [DATA_WIDTH-1:0]                  m_prdata_o;

    // Completer side
    logic [SLAVE_COUNT-1:0]                 sl_psel_o;
    logic                                   sl_penable_o;
    logic                                   sl_pwrite_o;
    logic [ADDR_WIDTH-1:0]                  sl_paddr_o;
    logic [DATA_WIDTH-1:0]                  sl_pwdata_o;
    logic [DATA_WIDTH/8-1:0]                sl_pstrb_o;
    logic [SLAVE_COUNT-1:0]                 sl_pready_i;
    logic [SLAVE_COUNT-1:0]                 sl_pslverr_i;
    logic [SLAVE_COUNT-1:0][DATA_WIDTH-1:0] sl_prdata_i;

    modport slave (
        input  m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i, m_pstrb_i,
        output m_pready_o, m_pslverr_o, m_prdata_o,
        output sl_psel_o, sl_penable_o, sl_pwrite_o, sl_paddr_o, sl_pwdata_o, sl_pstrb_o,
        input  sl_pready_i, sl_pslverr_i, sl_prdata_i
    );

    modport master (
        output m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i, m_pstrb_i,
        input  m_pready_o, m_pslverr_o, m_prdata_o,
        input  sl_psel_o, sl_penable_o, sl_pwrite_o, sl_paddr_o, sl_pwdata_o, sl_pstrb_o,
        output sl_pready_i, sl_pslverr_i, sl_prdata_i
    );
endinterface

// File: rtl/apb_demux_ctrl.sv
// Registered APB 1-to-N bridge. Captures one requester transfer, decodes the
// target completer from the address region index, replays SETUP/ACCESS on that
// completer and returns its response for one RESP cycle. Addresses outside the
// populated regions complete immediately with an error and touch no completer.
// Optional feature: define APB_DEMUX_TIMEOUT_EN to abort an ACCESS phase that
// sees no ready within TIMEOUT_CYCLES cycles (completes with error, rdata 0).
module apb_demux_ctrl #(
    parameter int SLAVE_COUNT    = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REGION_BITS    = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk_i,
    input  logic              presetn_i,
    apb_demux_ctrl_if.slave   bus
);

    localparam int IDX_W     = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int UPPER_LSB = REGION_BITS + IDX_W;
    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W+1)'(SLAVE_COUNT);

`ifdef APB_DEMUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;

    logic [SLAVE_COUNT-1:0]  psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_W-1:0]       pstrb_q;

    logic                    pready_q;
    logic                    pslverr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

`ifdef APB_DEMUX_TIMEOUT_EN
    logic [CNT_W-1:0]        tmo_cnt_q;
`endif

    logic                    setup_req;
    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_hit;
    logic [SLAVE_COUNT-1:0]  dec_onehot;
    logic                    upper_zero;

    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    // Address bits above the region index must be clear; with no such bits the check passes
    generate
        if (ADDR_WIDTH > UPPER_LSB) begin : g_upper
            assign upper_zero = (bus.m_paddr_i[ADDR_WIDTH-1:UPPER_LSB] == '0);
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    // Decode the requester setup phase into a region index and hit flag
    always_comb begin
        setup_req  = bus.m_psel_i & ~bus.m_penable_i;
        dec_idx    = bus.m_paddr_i[REGION_BITS +: IDX_W];
        dec_hit    = ({1'b0, dec_idx} < IDX_LIMIT) && upper_zero;
        dec_onehot = SLAVE_COUNT'(1) << dec_idx;
    end

    // Pick out the selected completer's response; other completers are ignored
    always_comb begin
        sel_ready = bus.sl_pready_i[idx_q];
        sel_err   = bus.sl_pslverr_i[idx_q];
        sel_rdata = bus.sl_prdata_i[idx_q];
    end

    // Transfer sequencer with registered completer- and requester-side outputs
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_DEMUX_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup_req) begin
                        paddr_q  <= bus.m_paddr_i;
                        pwrite_q <= bus.m_pwrite_i;
                        pwdata_q <= bus.m_pwdata_i;
                        pstrb_q  <= bus.m_pstrb_i;
                        idx_q    <= dec_idx;
                        if (dec_hit) begin
                            psel_q  <= dec_onehot;
                            state_q <= SETUP;
`ifdef APB_DEMUX_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end else begin
                            // Decode miss: answer straight away, no completer is selected
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                            state_q   <= RESP;
                        end
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end

                ACCESS: begin
                    if (sel_ready) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= sel_err;
                        prdata_q  <= pwrite_q ? '0 : sel_rdata;
                        state_q   <= RESP;
                    end
`ifdef APB_DEMUX_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                        state_q   <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`else
                    // Without the timeout, ACCESS holds until the completer is ready
`endif
                end

                RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    state_q   <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sl_psel_o    = psel_q;
    assign bus.sl_penable_o = penable_q;
    assign bus.sl_pwrite_o  = pwrite_q;
    assign bus.sl_paddr_o   = paddr_q;
    assign bus.sl_pwdata_o  = pwdata_q;
    assign bus.sl_pstrb_o   = pstrb_q;
    assign bus.m_pready_o   = pready_q;
    assign bus.m_pslverr_o  = pslverr_q;
    assign bus.m_prdata_o   = prdata_q;

endmodule

// File: tb/tb_apb_demux_ctrl.sv
// Directed self-checking bench for apb_demux_ctrl (3 completers, 32-bit bus,
// 4 KiB regions). Inputs change 1 time unit after the rising edge and outputs are
// sampled there too; every expected value below is worked out by hand.
module tb_apb_demux_ctrl;

    logic clk;
    logic rst_n;
    logic stray;
    logic slv_err;
    int   n_checks;
    int   n_errors;

    apb_demux_ctrl_if #(.SLAVE_COUNT(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    apb_demux_ctrl #(
        .SLAVE_COUNT   (3),
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .REGION_BITS   (12),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk_i   (clk),
        .presetn_i(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Selected completer answers with rdy/slv_err; the others drive the stray level
    task automatic drive_slaves(input int sidx, input logic rdy);
        for (int i = 0; i < 3; i++) begin
            bus.sl_pready_i[i]  = (i == sidx) ? rdy     : stray;
            bus.sl_pslverr_i[i] = (i == sidx) ? slv_err : stray;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/sl_psel"},    64'(bus.sl_psel_o),    '0);
        chk({tag, "/sl_penable"}, 64'(bus.sl_penable_o), '0);
        chk({tag, "/sl_pwrite"},  64'(bus.sl_pwrite_o),  '0);
        chk({tag, "/sl_paddr"},   64'(bus.sl_paddr_o),   '0);
        chk({tag, "/sl_pwdata"},  64'(bus.sl_pwdata_o),  '0);
        chk({tag, "/sl_pstrb"},   64'(bus.sl_pstrb_o),   '0);
        chk({tag, "/m_pready"},   64'(bus.m_pready_o),   '0);
        chk({tag, "/m_pslverr"},  64'(bus.m_pslverr_o),  '0);
        chk({tag, "/m_prdata"},   64'(bus.m_prdata_o),   '0);
    endtask

    // One requester transfer starting in an IDLE cycle. ready_at is the ACCESS cycle
    // (1-based) in which the selected completer raises ready (0 = never); n_access is
    // the expected number of ACCESS cycles, 0 meaning a decode miss.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int ready_at, input int n_access,
                        input logic [31:0] exp_rdata, input logic exp_err);
        logic [1:0] idx2;
        logic [2:0] exp_sel;
        int         sidx;
        idx2    = addr[13:12];
        sidx    = (n_access > 0) ? int'(idx2) : -1;
        exp_sel = (n_access > 0) ? (3'b001 << idx2) : 3'b000;

        chk({tag, "/idle_sel"},    64'(bus.sl_psel_o),  '0);
        chk({tag, "/idle_pready"}, 64'(bus.m_pready_o), '0);
        bus.m_psel_i    = 1'b1;
        bus.m_penable_i = 1'b0;
        bus.m_paddr_i   = addr;
        bus.m_pwrite_i  = wr;
        bus.m_pwdata_i  = wdata;
        bus.m_pstrb_i   = strb;
        drive_slaves(sidx, 1'b0);
        step();

        if (n_access > 0) begin
            chk({tag, "/setup_sel"},     64'(bus.sl_psel_o),    64'(exp_sel));
            chk({tag, "/setup_penable"}, 64'(bus.sl_penable_o), '0);
            chk({tag, "/setup_paddr"},   64'(bus.sl_paddr_o),   64'(addr));
            chk({tag, "/setup_pwrite"},  64'(bus.sl_pwrite_o),  64'(wr));
            chk({tag, "/setup_pwdata"},  64'(bus.sl_pwdata_o),  64'(wdata));
            chk({tag, "/setup_pstrb"},   64'(bus.sl_pstrb_o),   64'(strb));
            chk({tag, "/setup_pready"},  64'(bus.m_pready_o),   '0);
            bus.m_penable_i = 1'b1;
            step();
            for (int a = 1; a <= n_access; a++) begin
                drive_slaves(sidx, (a == ready_at) ? 1'b1 : 1'b0);
                chk($sformatf("%s/acc%0d_sel", tag, a),     64'(bus.sl_psel_o),    64'(exp_sel));
                chk($sformatf("%s/acc%0d_penable", tag, a), 64'(bus.sl_penable_o), 64'd1);
                chk($sformatf("%s/acc%0d_pwrite", tag, a),  64'(bus.sl_pwrite_o),  64'(wr));
                chk($sformatf("%s/acc%0d_pwdata", tag, a),  64'(bus.sl_pwdata_o),  64'(wdata));
                chk($sformatf("%s/acc%0d_pstrb", tag, a),   64'(bus.sl_pstrb_o),   64'(strb));
                chk($sformatf("%s/acc%0d_pready", tag, a),  64'(bus.m_pready_o),   '0);
                chk($sformatf("%s/acc%0d_prdata", tag, a),  64'(bus.m_prdata_o),   '0);
                step();
            end
        end

        chk({tag, "/resp_pready"},  64'(bus.m_pready_o),   64'd1);
        chk({tag, "/resp_prdata"},  64'(bus.m_prdata_o),   64'(exp_rdata));
        chk({tag, "/resp_pslverr"}, 64'(bus.m_pslverr_o),  64'(exp_err));
        chk({tag, "/resp_sel"},     64'(bus.sl_psel_o),    '0);
        chk({tag, "/resp_penable"}, 64'(bus.sl_penable_o), '0);
        bus.m_psel_i    = 1'b0;
        bus.m_penable_i = 1'b0;
        drive_slaves(-1, 1'b0);
        step();
        chk({tag, "/post_pready"},  64'(bus.m_pready_o),  '0);
        chk({tag, "/post_pslverr"}, 64'(bus.m_pslverr_o), '0);
        chk({tag, "/post_prdata"},  64'(bus.m_prdata_o),  '0);
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        stray            = 1'b0;
        slv_err          = 1'b0;
        rst_n            = 1'b0;
        bus.m_psel_i     = 1'b0;
        bus.m_penable_i  = 1'b0;
        bus.m_pwrite_i   = 1'b0;
        bus.m_paddr_i    = '0;
        bus.m_pwdata_i   = '0;
        bus.m_pstrb_i    = '0;
        bus.sl_pready_i  = '0;
        bus.sl_pslverr_i = '0;
        bus.sl_prdata_i[0] = 32'h0BAD_0BAD;
        bus.sl_prdata_i[1] = 32'hCAFE_F00D;
        bus.sl_prdata_i[2] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Read, slave 1, zero wait: RESP at cycle 3
        xfer("rd_s1", 32'h0000_1010, 1'b0, 32'h0, 4'hF, 1, 1, 32'hCAFE_F00D, 1'b0);
        // Write, slave 2, 3 wait states: RESP at cycle 6, prdata forced to 0
        xfer("wr_s2", 32'h0000_2004, 1'b1, 32'h1234_5678, 4'b0011, 4, 4, 32'h0, 1'b0);
        // Decode misses: index 3 unpopulated, and upper address bits set
        xfer("miss_3000",  32'h0000_3000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b1);
        xfer("miss_10000", 32'h0001_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0, 1'b1);
        repeat (2) step();
        xfer("miss_top",   32'h8000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b1);
        // Upper edge of region 2, back-to-back after the miss
        xfer("rd_s2_top", 32'h0000_2FFC, 1'b0, 32'h0, 4'hF, 1, 1, 32'hDEAD_BEEF, 1'b0);

        // Unselected completers drive ready and error throughout
        stray   = 1'b1;
        slv_err = 1'b1;
        xfer("err_s0", 32'h0000_0040, 1'b0, 32'h0, 4'hF, 2, 2, 32'h0BAD_0BAD, 1'b1);
        slv_err = 1'b0;
        xfer("stray_s0", 32'h0000_0FFC, 1'b0, 32'h0, 4'hF, 3, 3, 32'h0BAD_0BAD, 1'b0);
        xfer("stray_s2", 32'h0000_2000, 1'b1, 32'hA5A5_5A5A, 4'b1100, 2, 2, 32'h0, 1'b0);
        stray = 1'b0;

`ifdef APB_DEMUX_TIMEOUT_EN
        // Never ready: 16 ACCESS cycles then an error completion
        xfer("tmo_abort", 32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 16, 32'h0, 1'b1);
        // Ready on the 16th ACCESS cycle beats the limit
        xfer("tmo_ready", 32'h0000_0100, 1'b0, 32'h0, 4'hF, 16, 16, 32'h0BAD_0BAD, 1'b0);
`else
        // No limit: a late ready well past 16 cycles completes normally
        xfer("late_ready", 32'h0000_0100, 1'b0, 32'h0, 4'hF, 20, 20, 32'h0BAD_0BAD, 1'b0);
`endif

        // Reset while in ACCESS: outputs clear before the next edge
        bus.m_psel_i    = 1'b1;
        bus.m_penable_i = 1'b0;
        bus.m_paddr_i   = 32'h0000_0008;
        bus.m_pwrite_i  = 1'b1;
        bus.m_pwdata_i  = 32'hA5A5_A5A5;
        bus.m_pstrb_i   = 4'hF;
        drive_slaves(0, 1'b0);
        step();
        bus.m_penable_i = 1'b1;
        step();
        chk("rst_mid/access_penable", 64'(bus.sl_penable_o), 64'd1);
        chk("rst_mid/access_sel",     64'(bus.sl_psel_o),    64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid/async");
        bus.m_psel_i    = 1'b0;
        bus.m_penable_i = 1'b0;
        step();
        chk_all_zero("rst_mid/held");
        rst_n = 1'b1;
        step();
        xfer("rd_s1_after_rst", 32'h0000_1FFC, 1'b0, 32'h0, 4'hF, 2, 2, 32'hCAFE_F00D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
